// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared state encoding, op select codes and default width
//               for the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int c_default_width = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative shift-add multiplier / restoring divider with
//               sign correction, one step per cycle over a 2*WIDTH register.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                 c_cnt_w    = $clog2(ITERS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(ITERS);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_div_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               r_op;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   w_acc_hi;
    logic [WIDTH-1:0]   w_acc_lo;
    logic [WIDTH:0]     w_lhs;
    logic [WIDTH:0]     w_sum;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    assign w_a_mag    = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag    = (is_signed && b[WIDTH-1]) ? -b : b;
    assign w_div_zero = (op == OP_DIV) && (b == '0);

    assign w_acc_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_acc_lo = r_acc[WIDTH-1:0];

    // DIV trial-subtracts the remainder shifted left by one; MULT adds to the upper half
    assign w_lhs = (r_op == OP_DIV) ? {w_acc_hi, w_acc_lo[WIDTH-1]} : {1'b0, w_acc_hi};
    assign w_sum = (r_op == OP_DIV) ? (w_lhs - {1'b0, r_opnd}) : (w_lhs + {1'b0, r_opnd});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done   = (r_state == DONE) && !reset;
                w_next = IDLE;
                if (start && !reset) begin
                    w_accept = 1'b1;
                    busy     = 1'b1;
                    w_next   = w_div_zero ? FIX : CALC;
                end
            end
            CALC: begin
                busy = !reset;
                if (r_cnt == c_cnt_one) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                busy   = !reset;
                w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= OP_MULT;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (w_accept) begin
            r_op      <= op;
            r_neg_res <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_rem <= is_signed && a[WIDTH-1];
            r_dz      <= w_div_zero;
            r_cnt     <= c_cnt_load;
            r_dbz     <= 1'b0;
            r_opnd    <= (op == OP_DIV) ? w_b_mag : w_a_mag;
            // A zero divisor preloads its final raw result so FIX only copies it out
            r_acc     <= w_div_zero      ? {a, {WIDTH{1'b1}}} :
                         (op == OP_DIV)  ? {{WIDTH{1'b0}}, w_a_mag} :
                                           {{WIDTH{1'b0}}, w_b_mag};
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt - c_cnt_one;
            if (r_op == OP_DIV) begin
                r_acc <= w_sum[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_sum[WIDTH-1:0], w_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                r_acc <= w_acc_lo[0] ? {w_sum, w_acc_lo[WIDTH-1:1]}
                                     : {1'b0, r_acc[2*WIDTH-1:1]};
            end
        end else if (r_state == FIX) begin
            if (r_dz) begin
                r_hi  <= w_acc_hi;
                r_lo  <= w_acc_lo;
                r_dbz <= 1'b1;
            end else if (r_op == OP_DIV) begin
                r_hi <= r_neg_rem ? -w_acc_hi : w_acc_hi;
                r_lo <= r_neg_res ? -w_acc_lo : w_acc_lo;
            end else begin
                {r_hi, r_lo} <= r_neg_res ? -r_acc : r_acc;
            end
        end
    end

    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit against an arithmetic
//               reference model, directed corner cases plus random operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_unit #(.WIDTH(W), .ITERS(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Returns {hi, lo} computed directly from the arithmetic definition
    function automatic logic [63:0] model(input logic o, input logic s,
                                          input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] ux, uy, res;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (o == OP_MULT) begin
            if (s) res = sx * sy;
            else   res = ux * uy;
        end else if (y == 32'd0) begin
            res = {x, 32'hFFFF_FFFF};
        end else if (s) begin
            q   = sx / sy;
            r   = sx % sy;
            res = {r[31:0], q[31:0]};
        end else begin
            res = {(ux % uy) , 32'b0} | (ux / uy);
        end
        return res;
    endfunction

    task automatic launch(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y);
        op = o; is_signed = s; a = x; b = y; start = 1'b1;
        #1;
        check("busy_on_accept", busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 1'($urandom); is_signed = 1'($urandom);
    endtask

    task automatic finish_op(input logic o, input logic s, input logic [31:0] x,
                             input logic [31:0] y, input int inj);
        int          lat = 0;
        bit          busy_ok = 1'b1;
        logic [63:0] exp;
        exp = model(o, s, x, y);
        for (int k = 1; k <= 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (k == inj) begin
                start = 1'b1; a = 32'd9; b = 32'd9; op = OP_MULT; is_signed = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("latency", 64'(lat), 64'((o == OP_DIV && y == 32'd0) ? 2 : W + 2));
        check("busy_span", 64'(busy_ok), 1);
        check("hi", 64'(hi), 64'(exp[63:32]));
        check("lo", 64'(lo), 64'(exp[31:0]));
        check("div_by_zero", 64'(div_by_zero), 64'(o == OP_DIV && y == 32'd0));
    endtask

    initial begin
        logic        ro, rs;
        logic [31:0] rx, ry;
        bit          saw_done;
        reset = 1'b1; start = 1'b0; op = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_dbz", 64'(div_by_zero), 0);
        check("rst_hi", 64'(hi), 0);
        check("rst_lo", 64'(lo), 0);
        reset = 1'b0;

        // First cycle after reset, with a stray start injected mid-CALC
        launch(OP_MULT, 1'b0, 32'd7, 32'd6);
        finish_op(OP_MULT, 1'b0, 32'd7, 32'd6, 5);
        check("busy_in_done", 64'(busy), 0);
        @(posedge clk); #1;
        check("done_single_pulse", 64'(done), 0);
        check("hold_lo", 64'(lo), 42);

        launch(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5);
        finish_op(OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5, 0);
        launch(OP_DIV, 1'b0, 32'd100, 32'd7);
        finish_op(OP_DIV, 1'b0, 32'd100, 32'd7, 0);
        launch(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        finish_op(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        launch(OP_DIV, 1'b0, 32'd5, 32'd0);
        finish_op(OP_DIV, 1'b0, 32'd5, 32'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("dbz_sticky", 64'(div_by_zero), 1);
        launch(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("dbz_clear", 64'(div_by_zero), 0);
        finish_op(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Abort a multiply at cycle 10
        launch(OP_MULT, 1'b0, 32'd11, 32'd13);
        repeat (8) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 64'(busy), 0);
        check("abort_hi", 64'(hi), 0);
        check("abort_lo", 64'(lo), 0);
        saw_done = 1'b0;
        repeat (40) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_done", 64'(saw_done), 0);
        launch(OP_MULT, 1'b0, 32'd2, 32'd3);
        finish_op(OP_MULT, 1'b0, 32'd2, 32'd3, 0);

        for (int i = 0; i < 25; i++) begin
            ro = 1'($urandom);
            rs = 1'($urandom);
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: ry = 32'($urandom_range(1, 15));
                default: ;
            endcase
            launch(ro, rs, rx, ry);
            finish_op(ro, rs, rx, ry, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
